// File: rtl/change_stim_pkg.sv
// Shared definitions for the change_stim_driver sequencer: state encoding,
// default widths, LFSR taps and the LFSR next-value function.
package change_stim_pkg;

   localparam int DEF_DATA_W = 15;
   localparam int DEF_IDX_W  = 4;
   localparam int STEP_W     = 8;
   localparam int LFSR_W     = 15;
   localparam int LFSR_TAP_HI = 14;
   localparam int LFSR_TAP_LO = 13;

   // State encoding kept as plain constants for compatibility with older fixtures.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WALK  = 3'd1;
   localparam logic [2:0] ST_SWEEP = 3'd2;
   localparam logic [2:0] ST_LFSR  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
   endfunction

endpackage

// File: rtl/lfsr15.sv
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1) with synchronous reload and
// step enable; the asynchronous reset also loads the seed.
module lfsr15
   import change_stim_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   // Shift register: reload has priority over stepping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= seed;
      end else if (load) begin
         q <= seed;
      end else if (step) begin
         q <= lfsr_next(q);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/change_stim_driver.sv
// Clocked stimulus sequencer: walking one, index sweep, optional LFSR phase.
// Define CHANGE_STIM_LFSR_EN to compile in the LFSR phase and lfsr15 instance.
module change_stim_driver
   import change_stim_pkg::*;
#(
   parameter int               DATA_W     = DEF_DATA_W,
   parameter int               IDX_W      = DEF_IDX_W,
   parameter int               LFSR_STEPS = 8,
   parameter logic [LFSR_W-1:0] SEED      = 15'h0001
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ready,
   output logic [DATA_W-1:0] data,
   output logic [IDX_W-1:0]  idx,
   output logic              valid,
   output logic              busy,
   output logic              done
);

   localparam logic [STEP_W-1:0] WALK_LAST  = STEP_W'(DATA_W - 1);
   localparam logic [STEP_W-1:0] SWEEP_LAST = STEP_W'((1 << IDX_W) - 1);
`ifdef CHANGE_STIM_LFSR_EN
   localparam logic [STEP_W-1:0] LFSR_LAST  = STEP_W'(LFSR_STEPS - 1);
   localparam logic [2:0]        SWEEP_EXIT = ST_LFSR;
`else
   localparam logic [2:0]        SWEEP_EXIT = ST_DONE;
`endif

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic [STEP_W-1:0] step_r;
   logic [STEP_W-1:0] step_nxt_s;
   logic              accept_s;
   logic [DATA_W-1:0] data_nxt_s;
   logic [IDX_W-1:0]  idx_nxt_s;
   logic              valid_nxt_s;
   logic              busy_nxt_s;
   logic              done_nxt_s;

   assign accept_s = valid & ready;

`ifdef CHANGE_STIM_LFSR_EN
   logic [LFSR_W-1:0] lfsr_q_s;
   logic [LFSR_W-1:0] lfsr_item_s;
   logic              lfsr_load_s;
   logic              lfsr_step_s;

   assign lfsr_step_s = (state_r == ST_LFSR) & accept_s;
   assign lfsr_load_s = (state_r == ST_DONE);
   // The item presented next is the value the register holds after this edge.
   assign lfsr_item_s = lfsr_step_s ? lfsr_next(lfsr_q_s) : lfsr_q_s;

   lfsr15 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load_s),
      .step (lfsr_step_s),
      .seed (SEED),
      .q    (lfsr_q_s)
   );
`else
   logic unused_cfg_s;
   assign unused_cfg_s = ^{SEED, 32'(LFSR_STEPS)};
`endif

   // Phase sequencing; the step counter advances only on accept.
   always_comb begin
      state_nxt_s = state_r;
      step_nxt_s  = step_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_WALK;
               step_nxt_s  = 8'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WALK: begin
            if (accept_s && (step_r == WALK_LAST)) begin
               state_nxt_s = ST_SWEEP;
               step_nxt_s  = 8'd0;
            end else if (accept_s) begin
               step_nxt_s = step_r + 8'd1;
            end else begin
               step_nxt_s = step_r;
            end
         end
         ST_SWEEP: begin
            if (accept_s && (step_r == SWEEP_LAST)) begin
               state_nxt_s = SWEEP_EXIT;
               step_nxt_s  = 8'd0;
            end else if (accept_s) begin
               step_nxt_s = step_r + 8'd1;
            end else begin
               step_nxt_s = step_r;
            end
         end
`ifdef CHANGE_STIM_LFSR_EN
         ST_LFSR: begin
            if (accept_s && (step_r == LFSR_LAST)) begin
               state_nxt_s = ST_DONE;
               step_nxt_s  = 8'd0;
            end else if (accept_s) begin
               step_nxt_s = step_r + 8'd1;
            end else begin
               step_nxt_s = step_r;
            end
         end
`endif
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            step_nxt_s  = 8'd0;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            step_nxt_s  = 8'd0;
         end
      endcase
   end

   // Output values for the upcoming state, so outputs can be registered.
   always_comb begin
      data_nxt_s  = {DATA_W{1'b0}};
      idx_nxt_s   = {IDX_W{1'b0}};
      valid_nxt_s = 1'b0;
      busy_nxt_s  = 1'b0;
      done_nxt_s  = 1'b0;
      case (state_nxt_s)
         ST_WALK: begin
            data_nxt_s  = {{(DATA_W-1){1'b0}}, 1'b1} << step_nxt_s;
            idx_nxt_s   = step_nxt_s[IDX_W-1:0];
            valid_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
         end
         ST_SWEEP: begin
            data_nxt_s  = {DATA_W{1'b1}};
            idx_nxt_s   = step_nxt_s[IDX_W-1:0];
            valid_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
         end
`ifdef CHANGE_STIM_LFSR_EN
         ST_LFSR: begin
            data_nxt_s  = DATA_W'(lfsr_item_s);
            idx_nxt_s   = lfsr_item_s[IDX_W-1:0];
            valid_nxt_s = 1'b1;
            busy_nxt_s  = 1'b1;
         end
`endif
         ST_DONE: begin
            busy_nxt_s = 1'b1;
            done_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         step_r  <= 8'd0;
         data    <= {DATA_W{1'b0}};
         idx     <= {IDX_W{1'b0}};
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         step_r  <= step_nxt_s;
         data    <= data_nxt_s;
         idx     <= idx_nxt_s;
         valid   <= valid_nxt_s;
         busy    <= busy_nxt_s;
         done    <= done_nxt_s;
      end
   end

endmodule

// File: tb/tb_change_stim_driver.sv
// Self-checking bench for change_stim_driver; expected items come from a
// queue built directly from the phase rules (honours CHANGE_STIM_LFSR_EN).
module tb_change_stim_driver;

   localparam int DW = 15;
   localparam int IW = 4;
   localparam int NSTEPS = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          ready;
   logic [DW-1:0] data;
   logic [IW-1:0] idx;
   logic          valid;
   logic          busy;
   logic          done;

   int vectors = 0;
   int errors  = 0;
   int exp_d[$];
   int exp_i[$];

   change_stim_driver dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ready (ready),
      .data  (data),
      .idx   (idx),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      vectors++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, expv);
      end
   endtask

   task automatic build_expected();
      int v;
      exp_d.delete();
      exp_i.delete();
      for (int k = 0; k < DW; k++) begin
         exp_d.push_back(1 << k);
         exp_i.push_back(k % (1 << IW));
      end
      for (int j = 0; j < (1 << IW); j++) begin
         exp_d.push_back((1 << DW) - 1);
         exp_i.push_back(j);
      end
`ifdef CHANGE_STIM_LFSR_EN
      v = 1;
      for (int n = 0; n < NSTEPS; n++) begin
         exp_d.push_back(v);
         exp_i.push_back(v % (1 << IW));
         v = ((v * 2) + (((v >> 14) ^ (v >> 13)) & 1)) % (1 << 15);
      end
`else
      v = 0;
`endif
   endtask

   // Runs one full sequence from IDLE, starting and ending at a negedge.
   task automatic run_seq(input int rmode, input int start_at);
      int item;
      int cyc;
      int stall;
      item = 0;
      cyc = 0;
      stall = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (item < exp_d.size() && cyc < 4000) begin
         chk("valid", 32'(valid), 32'd1);
         chk("busy", 32'(busy), 32'd1);
         chk("done_early", 32'(done), 32'd0);
         chk("data", 32'(data), exp_d[item]);
         chk("idx", 32'(idx), exp_i[item]);
         case (rmode)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            default: begin
               if (item == 3 && stall < 5) begin
                  ready = 1'b0;
                  stall++;
               end else begin
                  ready = 1'b1;
               end
            end
         endcase
         start = (item == start_at);
         @(negedge clk);
         if (ready) item++;
         cyc++;
      end
      start = 1'b0;
      chk("item_count", item, exp_d.size());
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_valid", 32'(valid), 32'd0);
      chk("done_data", 32'(data), 32'd0);
      chk("done_idx", 32'(idx), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      ready = 1'($urandom_range(0, 1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_data", 32'(data), 32'd0);
   endtask

   initial begin
      build_expected();
      rst = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      chk("idle_ready_valid", 32'(valid), 32'd0);
      chk("idle_ready_busy", 32'(busy), 32'd0);

      run_seq(0, -1);
      run_seq(2, -1);
      run_seq(0, 10);

      // Asynchronous reset in the middle of SWEEP j=7.
      ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (DW + 7) @(negedge clk);
      chk("pre_rst_data", 32'(data), (1 << DW) - 1);
      chk("pre_rst_idx", 32'(idx), 32'd7);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_data", 32'(data), 32'd0);
      chk("arst_idx", 32'(idx), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);

      run_seq(0, -1);
      run_seq(1, -1);
      run_seq(1, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
